osc_phase_reader: RTL and testbench

OSC_PHASE_READER -- requirements
Module: osc_phase_reader

---
 rtl/osc_phase_reader.sv | 135 +++++++++++++
 tb/tb_osc_phase_reader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/osc_phase_reader.sv
// Phase readout for N coupled oscillators: counts in-phase samples against a reference
// and decides one spin per oscillator by strict majority. Optional macro OSC_PHASE_READER_COUNT_EN exposes raw counts.
module osc_phase_reader #(
  parameter int N     = 8,
  parameter int WIN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIN_W-1:0] window_len,
  input  logic [N-1:0]     osc_in,
  input  logic             ref_in,
  output logic             busy,
  output logic [N-1:0]     spin_out,
  output logic             spin_valid,
  input  logic             spin_ready
`ifdef OSC_PHASE_READER_COUNT_EN
  ,
  output logic [N*WIN_W-1:0] match_count
`endif
);

  typedef enum logic [2:0] {IDLE, FLUSH, SAMPLE, DECIDE, OUTPUT} state_t;

  state_t           state_q, state_d;
  logic [WIN_W-1:0] len_q, len_d;
  logic [WIN_W-1:0] phase_q, phase_d;
  logic [WIN_W-1:0] cnt_q [N];
  logic [WIN_W-1:0] cnt_d [N];
  logic [N-1:0]     spin_q, spin_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [N-1:0]     osc_meta_q, osc_sync_q;
  logic             ref_meta_q, ref_sync_q;
  logic [N-1:0]     match;
  logic [N-1:0]     majority;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_osc
      assign match[gi]    = (osc_sync_q[gi] == ref_sync_q);
      // Compare 2*count against L in one extra bit so neither side can wrap.
      assign majority[gi] = {cnt_q[gi], 1'b0} > {1'b0, len_q};
`ifdef OSC_PHASE_READER_COUNT_EN
      assign match_count[gi*WIN_W +: WIN_W] = cnt_q[gi];
`endif
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    spin_d  = spin_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FLUSH;
          len_d   = (window_len == '0) ? WIN_W'(1) : window_len;
          phase_d = '0;
          for (int i = 0; i < N; i++) cnt_d[i] = '0;
        end
      end
      FLUSH: begin
        // Two cycles let the synchronizers drain anything captured before start.
        if (phase_q == WIN_W'(1)) begin
          state_d = SAMPLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + WIN_W'(1);
        end
      end
      SAMPLE: begin
        for (int i = 0; i < N; i++) begin
          if (match[i]) cnt_d[i] = cnt_q[i] + WIN_W'(1);
        end
        if (phase_q == len_q - WIN_W'(1)) begin
          state_d = DECIDE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + WIN_W'(1);
        end
      end
      DECIDE: begin
        spin_d  = majority;
        state_d = OUTPUT;
      end
      OUTPUT: begin
        if (valid_q && spin_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      phase_q    <= '0;
      spin_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      osc_meta_q <= '0;
      osc_sync_q <= '0;
      ref_meta_q <= 1'b0;
      ref_sync_q <= 1'b0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      phase_q    <= phase_d;
      spin_q     <= spin_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      osc_meta_q <= osc_in;
      osc_sync_q <= osc_meta_q;
      ref_meta_q <= ref_in;
      ref_sync_q <= ref_meta_q;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign busy       = busy_q;
  assign spin_out   = spin_q;
  assign spin_valid = valid_q;

endmodule

// File: tb/tb_osc_phase_reader.sv
// Directed bench for osc_phase_reader: vector table plus tie, hold and reset-abort sequences.
module tb_osc_phase_reader;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         spin_ready = 1'b0;
  logic         ref_in = 1'b0;
  logic [W-1:0] window_len = '0;
  logic [N-1:0] osc_in = '0;
  logic         busy;
  logic [N-1:0] spin_out;
  logic         spin_valid;
`ifdef OSC_PHASE_READER_COUNT_EN
  logic [N*W-1:0] match_count;
`endif

  osc_phase_reader #(.N(N), .WIN_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .window_len (window_len),
    .osc_in     (osc_in),
    .ref_in     (ref_in),
    .busy       (busy),
    .spin_out   (spin_out),
    .spin_valid (spin_valid),
    .spin_ready (spin_ready)
`ifdef OSC_PHASE_READER_COUNT_EN
    ,
    .match_count(match_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Oscillator driver: either a reference toggling every 3 clocks with osc = ref ^ mask,
  // or manual values set by the main sequence.
  logic         auto_en = 1'b1;
  logic [N-1:0] inv_mask = '0;
  logic [N-1:0] man_osc = '0;
  logic         man_ref = 1'b0;
  int           ph = 0;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (auto_en) begin
        ph = (ph + 1) % 3;
        if (ph == 0) ref_in = ~ref_in;
        osc_in = {N{ref_in}} ^ inv_mask;
      end else begin
        ref_in = man_ref;
        osc_in = man_osc;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  task automatic start_run(input logic [W-1:0] len);
    @(negedge clk);
    window_len = len;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    window_len = ~len;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk);
      #1;
      if (spin_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic finish_handshake(input logic [N-1:0] exp_spin);
    spin_ready = 1'b1;
    @(posedge clk);
    #1;
    spin_ready = 1'b0;
    check("handshake_valid_busy", {30'd0, spin_valid, busy}, 32'd0);
    check("idle_spin_retained", {28'd0, spin_out}, {28'd0, exp_spin});
  endtask

  typedef struct {
    logic [W-1:0] len;
    logic [N-1:0] mask;
    logic [N-1:0] exp_spin;
    int           exp_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    int leff;
    int seen;

    vecs[0] = '{len: 8'd10,  mask: 4'b0000, exp_spin: 4'b1111, exp_lat: 14};
    vecs[1] = '{len: 8'd10,  mask: 4'b0001, exp_spin: 4'b1110, exp_lat: 14};
    vecs[2] = '{len: 8'd0,   mask: 4'b0101, exp_spin: 4'b1010, exp_lat: 5};
    vecs[3] = '{len: 8'd1,   mask: 4'b1000, exp_spin: 4'b0111, exp_lat: 5};
    vecs[4] = '{len: 8'd3,   mask: 4'b1111, exp_spin: 4'b0000, exp_lat: 7};
    vecs[5] = '{len: 8'd255, mask: 4'b0110, exp_spin: 4'b1001, exp_lat: 259};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {26'd0, busy, spin_valid, spin_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int v = 0; v < 6; v++) begin
      auto_en  = 1'b1;
      inv_mask = vecs[v].mask;
      repeat (2) @(posedge clk);
      start_run(vecs[v].len);
      wait_valid(lat);
      check($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
      check($sformatf("vec%0d_spin", v), {28'd0, spin_out}, {28'd0, vecs[v].exp_spin});
`ifdef OSC_PHASE_READER_COUNT_EN
      leff = (vecs[v].len == 0) ? 1 : int'(vecs[v].len);
      for (int i = 0; i < N; i++)
        check($sformatf("vec%0d_count%0d", v, i), {24'd0, match_count[i*W +: W]},
              vecs[v].mask[i] ? 32'd0 : leff);
`endif
      finish_handshake(vecs[v].exp_spin);
    end

    // Tie: ref held low, osc2 low for two sampled cycles then high; stale pre-start highs must not count.
    auto_en = 1'b0;
    man_ref = 1'b0;
    man_osc = 4'b1100;
    repeat (4) @(posedge clk);
    start_run(8'd4);
    man_osc = 4'b1000;
    repeat (2) @(posedge clk);
    #1;
    man_osc = 4'b1100;
    wait_valid(lat);
    check("tie_latency", lat + 2, 8);
    check("tie_spin", {28'd0, spin_out}, 32'h3);
`ifdef OSC_PHASE_READER_COUNT_EN
    check("tie_count2", {24'd0, match_count[2*W +: W]}, 32'd2);
`endif
    finish_handshake(4'b0011);

    // Backpressure: result held for 20 cycles, a start pulse in OUTPUT is ignored.
    auto_en  = 1'b1;
    inv_mask = 4'b0100;
    repeat (2) @(posedge clk);
    start_run(8'd6);
    wait_valid(lat);
    check("hold_latency", lat, 10);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (c == 19 || c % 5 == 0)
        check($sformatf("hold_c%0d", c), {27'd0, spin_valid, spin_out}, {27'd0, 1'b1, 4'b1011});
      if (c == 5) begin
        start = 1'b1;
        window_len = 8'd2;
      end
    end
    finish_handshake(4'b1011);
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (busy) seen++;
    end
    check("ignored_start_no_run", seen, 0);

    // Reset during SAMPLE aborts the readout with no residue.
    inv_mask = 4'b0000;
    start_run(8'd10);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {26'd0, busy, spin_valid, spin_out}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (spin_valid || busy) seen++;
    end
    check("no_valid_after_abort", seen, 0);
    inv_mask = 4'b0010;
    start_run(8'd10);
    wait_valid(lat);
    check("post_reset_latency", lat, 14);
    check("post_reset_spin", {28'd0, spin_out}, 32'hD);
`ifdef OSC_PHASE_READER_COUNT_EN
    check("post_reset_count0", {24'd0, match_count[0 +: W]}, 32'd10);
`endif
    finish_handshake(4'b1101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
